// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: arbitrates two AES requesters (0 = encrypt, 1 = decrypt)
// onto one engine with round-robin grant, one-cycle launch and a held response.
// Optional engine watchdog: define AES_SCHED_TIMEOUT_EN.
module aes_job_scheduler #(
  parameter int NK             = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [255:0]    req_msg,
  input  logic [32*NK-1:0] key,
  output logic            eng_cs_enc,
  output logic            eng_cs_dec,
  output logic            eng_start,
  output logic [127:0]    eng_msg,
  output logic [32*NK-1:0] eng_key,
  input  logic            eng_done,
  input  logic [127:0]    eng_result,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [127:0]    rsp_data,
  output logic            rsp_err,
  output logic [15:0]     job_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic            g;        // grant index of the active job
  logic            last;     // requester served most recently
  logic            gnt;
  logic            accept;
  logic            rsp_hs;
  logic            tmo_hit;
  logic [127:0]    msg_q;
  logic [32*NK-1:0] key_q;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          err_q;
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next state, round-robin grant and handshake strobes
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    gnt       = 1'b0;
    accept    = 1'b0;
    rsp_hs    = 1'b0;
    case (state)
      IDLE: if (rst && req_valid != 2'b00) begin
        gnt       = (req_valid == 2'b11) ? ~last : req_valid[1];
        req_ready = gnt ? 2'b10 : 2'b01;
        accept    = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (eng_done)     state_nxt = RESP;
        else if (tmo_hit) state_nxt = RESP;
      end
      RESP: if (rsp_ready[g]) begin
        rsp_hs    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // job capture, result capture, pointer and completion counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g         <= 1'b0;
      last      <= 1'b1;
      msg_q     <= '0;
      key_q     <= '0;
      rsp_data  <= '0;
      job_count <= '0;
    end else begin
      if (accept) begin
        g     <= gnt;
        msg_q <= gnt ? req_msg[255:128] : req_msg[127:0];
        key_q <= key;
      end
      if (state == WAIT) begin
        if (eng_done)     rsp_data <= eng_result;
        else if (tmo_hit) rsp_data <= '0;
      end
      if (rsp_hs) begin
        last      <= g;
        job_count <= job_count + 16'd1;
      end
    end
  end

`ifdef AES_SCHED_TIMEOUT_EN
  // watchdog counter and error flag; eng_done wins over the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == ISSUE)     tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + CW'(1);
      if (state == WAIT) begin
        if (eng_done)     err_q <= 1'b0;
        else if (tmo_hit) err_q <= 1'b1;
      end
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign eng_start  = (state == ISSUE);
  assign eng_cs_enc = (state != IDLE) && !g;
  assign eng_cs_dec = (state != IDLE) &&  g;
  assign eng_msg    = msg_q;
  assign eng_key    = key_q;
  assign rsp_valid  = (state == RESP) ? (g ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler: vector table plus corner-case sequences.
module tb_aes_job_scheduler;
  localparam int NK = 8;
  localparam logic [127:0] M0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] M1  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C0  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [255:0] req_msg = {M1, M0};
  logic [32*NK-1:0] key = KEY, eng_key;
  logic eng_cs_enc, eng_cs_dec, eng_start, eng_done = 1'b0, rsp_err;
  logic [127:0] eng_msg, eng_result = '0, rsp_data;
  logic [15:0] job_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  aes_job_scheduler #(.NK(NK), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_msg(req_msg), .key(key), .eng_cs_enc(eng_cs_enc), .eng_cs_dec(eng_cs_dec),
    .eng_start(eng_start), .eng_msg(eng_msg), .eng_key(eng_key), .eng_done(eng_done),
    .eng_result(eng_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .job_count(job_count)
  );

  typedef struct {
    logic rst; logic [1:0] rv; logic done; logic [1:0] rr; logic [127:0] res;
    logic [1:0] e_rdy; logic e_st, e_enc, e_dec; logic [1:0] e_rspv; logic [15:0] e_jc;
    logic cm; logic [127:0] e_msg; logic cd; logic [127:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [1:0] rv, input logic d,
                              input logic [1:0] rr, input logic [127:0] res,
                              input logic [1:0] rdy, input logic st, en, de,
                              input logic [1:0] rspv, input logic [15:0] jc,
                              input logic cm, input logic [127:0] m,
                              input logic cd, input logic [127:0] dat);
    vec_t v;
    v.rst = r; v.rv = rv; v.done = d; v.rr = rr; v.res = res;
    v.e_rdy = rdy; v.e_st = st; v.e_enc = en; v.e_dec = de; v.e_rspv = rspv; v.e_jc = jc;
    v.cm = cm; v.e_msg = m; v.cd = cd; v.e_data = dat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // minimal job: grant, issue, done in first WAIT, response taken at once
  task automatic run_job(input logic [1:0] rv, input logic [127:0] res);
    req_valid = rv; tick;
    req_valid = 2'b00; tick;
    eng_done = 1'b1; eng_result = res; tick;
    eng_done = 1'b0; rsp_ready = 2'b11; tick;
    rsp_ready = 2'b00;
  endtask

  function automatic logic [127:0] rk(input int k);
    return {4{32'hA5A50000 + 32'(k)}};
  endfunction

  initial begin
    logic gk;

    // contention: both requesters held for four jobs, grants 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      gk = k[0];
      tbl.push_back(mk(1, 2'b11, 0, 2'b00, '0, gk ? 2'b10 : 2'b01, 0, 0, 0, 2'b00, 16'(k), 0, '0, 0, '0));
      tbl.push_back(mk(1, 2'b11, 1, 2'b00, '0, 2'b00, 1, !gk, gk, 2'b00, 16'(k), 1, gk ? M1 : M0, 0, '0));
      tbl.push_back(mk(1, 2'b11, 1, 2'b00, rk(k), 2'b00, 0, !gk, gk, 2'b00, 16'(k), 0, '0, 0, '0));
      tbl.push_back(mk(1, 2'b11, 0, 2'b11, '0, 2'b00, 0, !gk, gk, gk ? 2'b10 : 2'b01, 16'(k), 0, '0, 1, rk(k)));
    end
    // reset with a pending request: everything forced low
    tbl.push_back(mk(0, 2'b01, 0, 2'b00, '0, 2'b00, 0, 0, 0, 2'b00, 16'd0, 1, '0, 1, '0));
    // single encrypt, eng_done after 5 WAIT cycles
    tbl.push_back(mk(1, 2'b01, 0, 2'b00, '0, 2'b01, 0, 0, 0, 2'b00, 16'd0, 0, '0, 0, '0));
    tbl.push_back(mk(1, 2'b00, 0, 2'b00, '0, 2'b00, 1, 1, 0, 2'b00, 16'd0, 1, M0, 0, '0));
    for (int c = 0; c < 5; c++)
      tbl.push_back(mk(1, 2'b00, 0, 2'b00, '0, 2'b00, 0, 1, 0, 2'b00, 16'd0, 0, '0, 0, '0));
    tbl.push_back(mk(1, 2'b00, 1, 2'b00, C0, 2'b00, 0, 1, 0, 2'b00, 16'd0, 0, '0, 0, '0));
    tbl.push_back(mk(1, 2'b00, 0, 2'b01, '0, 2'b00, 0, 1, 0, 2'b01, 16'd0, 0, '0, 1, C0));
    tbl.push_back(mk(1, 2'b00, 0, 2'b00, '0, 2'b00, 0, 0, 0, 2'b00, 16'd1, 0, '0, 0, '0));

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.jc", job_count, 16'd0);
    chk("rst.rspv", rsp_valid, 2'b00);
    chk("rst.msg", eng_msg, '0);
    chk("rst.key", eng_key[127:0], '0);
    chk("rst.cs", {eng_cs_enc, eng_cs_dec, eng_start, rsp_err}, 4'b0000);
    rst = 1'b1;

    foreach (tbl[i]) begin
      rst = tbl[i].rst; req_valid = tbl[i].rv; eng_done = tbl[i].done;
      rsp_ready = tbl[i].rr; eng_result = tbl[i].res;
      #1;
      chk($sformatf("v%0d.rdy", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d.start", i), eng_start, tbl[i].e_st);
      chk($sformatf("v%0d.enc", i), eng_cs_enc, tbl[i].e_enc);
      chk($sformatf("v%0d.dec", i), eng_cs_dec, tbl[i].e_dec);
      chk($sformatf("v%0d.rspv", i), rsp_valid, tbl[i].e_rspv);
      chk($sformatf("v%0d.jc", i), job_count, tbl[i].e_jc);
      if (tbl[i].cm) chk($sformatf("v%0d.msg", i), eng_msg, tbl[i].e_msg);
      if (tbl[i].cd) chk($sformatf("v%0d.data", i), rsp_data, tbl[i].e_data);
      if (tbl[i].cd) chk($sformatf("v%0d.err", i), rsp_err, 1'b0);
      tick;
    end

    // backpressure: other-bit rsp_ready and new requests ignored in RESP
    rst = 1'b1; req_valid = 2'b01; eng_done = 1'b0; rsp_ready = 2'b00;
    #1 chk("bp.rdy", req_ready, 2'b01);
    tick;
    req_valid = 2'b11;
    #1 chk("bp.key", eng_key, KEY);
    chk("bp.rdy_issue", req_ready, 2'b00);
    tick;
    eng_done = 1'b1; eng_result = rk(5); tick;
    eng_result = ~rk(5); rsp_ready = 2'b10;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp.rspv", rsp_valid, 2'b01);
      chk("bp.data", rsp_data, rk(5));
      chk("bp.rdy_resp", req_ready, 2'b00);
      chk("bp.jc", job_count, 16'd1);
      tick;
    end
    rsp_ready = 2'b01; eng_done = 1'b0;
    #1 chk("bp.rspv_last", rsp_valid, 2'b01);
    tick;
    req_valid = 2'b00; rsp_ready = 2'b00;
    #1 chk("bp.rspv_done", rsp_valid, 2'b00);
    chk("bp.jc_done", job_count, 16'd2);

    // reset mid-WAIT, late eng_done ignored, next request served
    req_valid = 2'b10;
    #1 chk("rw.rdy", req_ready, 2'b10);
    tick;
    req_valid = 2'b00; tick;
    #1 chk("rw.dec", eng_cs_dec, 1'b1);
    rst = 1'b0;
    #1;
    chk("rw.zero_a", {req_ready, rsp_valid, rsp_err, eng_start, eng_cs_enc, eng_cs_dec}, 8'h00);
    chk("rw.zero_msg", eng_msg, '0);
    chk("rw.zero_key", eng_key[255:128], '0);
    chk("rw.zero_data", rsp_data, '0);
    chk("rw.zero_jc", job_count, 16'd0);
    tick;
    rst = 1'b1; eng_done = 1'b1; eng_result = rk(6);
    for (int c = 0; c < 3; c++) begin
      #1 chk("rw.quiet", {rsp_valid, eng_start, eng_cs_enc, eng_cs_dec}, 5'b00000);
      tick;
    end
    eng_done = 1'b0; req_valid = 2'b01;
    #1 chk("rw.rdy_next", req_ready, 2'b01);
    tick;
    req_valid = 2'b00; tick;
    eng_done = 1'b1; eng_result = rk(7); tick;
    eng_done = 1'b0; rsp_ready = 2'b01;
    #1 chk("rw.rspv_next", rsp_valid, 2'b01);
    chk("rw.data_next", rsp_data, rk(7));
    tick;
    rsp_ready = 2'b00;
    #1 chk("rw.jc_next", job_count, 16'd1);

    // counter wrap from 0xFFFF
    force dut.job_count = 16'hFFFF;
    #1 release dut.job_count;
    #1 chk("wrap.pre", job_count, 16'hFFFF);
    run_job(2'b01, rk(8));
    #1 chk("wrap.post", job_count, 16'h0000);

`ifdef AES_SCHED_TIMEOUT_EN
    // watchdog fires after 16 WAIT cycles
    req_valid = 2'b01; tick;
    req_valid = 2'b00; tick;
    for (int c = 0; c < 16; c++) begin
      #1 chk("to.wait", rsp_valid, 2'b00);
      tick;
    end
    #1 chk("to.rspv", rsp_valid, 2'b01);
    chk("to.err", rsp_err, 1'b1);
    chk("to.data", rsp_data, '0);
    rsp_ready = 2'b01; tick;
    rsp_ready = 2'b00;
    // eng_done on the limit cycle wins
    req_valid = 2'b01; tick;
    req_valid = 2'b00; tick;
    for (int c = 0; c < 15; c++) begin
      #1 chk("to2.wait", rsp_valid, 2'b00);
      tick;
    end
    eng_done = 1'b1; eng_result = rk(9); tick;
    eng_done = 1'b0;
    #1 chk("to2.rspv", rsp_valid, 2'b01);
    chk("to2.err", rsp_err, 1'b0);
    chk("to2.data", rsp_data, rk(9));
    rsp_ready = 2'b01; tick;
    rsp_ready = 2'b00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_job_scheduler.md
AES_JOB_SCHEDULER -- requirements
Module: aes_job_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NK, 8, key length in 32-bit words (8 = AES-256).
- TIMEOUT_CYCLES, 4096, engine watchdog limit in clk cycles; used only when AES_SCHED_TIMEOUT_EN is defined.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  2  request pending; bit0 = encrypt requester, bit1 = decrypt requester.
- req_ready  out  2  request accepted; at most one bit set.
- req_msg  in  256  [127:0] = requester 0 block, [255:128] = requester 1 block.
- key  in  32*NK  shared key.
- eng_cs_enc  out  1  selects the encryption unit.
- eng_cs_dec  out  1  selects the decryption unit.
- eng_start  out  1  one-cycle job launch pulse (valid_curr_data).
- eng_msg  out  128  block presented to the engine.
- eng_key  out  32*NK  key presented to the engine.
- eng_done  in  1  engine result valid.
- eng_result  in  128  engine output block.
- rsp_valid  out  2  response pending for requester g.
- rsp_ready  in  2  requester accepts response.
- rsp_data  out  128  result block.
- rsp_err  out  1  response is a timeout error.
- job_count  out  16  completed response handshakes.

Function
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-005 In IDLE, req_ready SHALL combinationally assert for exactly one requester with req_valid set, chosen by round-robin. The requester not served last SHALL win when both are valid. After reset, requester 0 SHALL win.
REQ-006 On a req_valid&req_ready handshake, the block SHALL register the grant index g, the selected msg slice, and key, then enter ISSUE.
REQ-007 ISSUE SHALL last exactly one cycle: eng_start=1, eng_msg and eng_key driven from the registers, then enter WAIT.
REQ-008 eng_cs_enc SHALL be 1 iff state!=IDLE and g=0. eng_cs_dec SHALL be 1 iff state!=IDLE and g=1. Both SHALL never be 1 together.
REQ-009 eng_done SHALL be sampled only in WAIT and ignored in every other state.
- On eng_done in WAIT: capture eng_result into rsp_data, set rsp_err=0, enter RESP.
REQ-010 In RESP, rsp_valid[g] SHALL hold 1 and rsp_data/rsp_err SHALL stay stable until rsp_ready[g]=1.
- Then: return to IDLE, set the last-served pointer to g, increment job_count.
- rsp_ready on the other bit SHALL be ignored.
REQ-011 job_count SHALL wrap from 0xFFFF to 0x0000.
REQ-012 req_ready SHALL be 0 in every state except IDLE. No request is accepted while a job is active.
REQ-013 Minimum latency from request handshake to rsp_valid SHALL be 3 cycles, with eng_done returned in the first WAIT cycle.
REQ-014 A req_valid change during ISSUE, WAIT or RESP SHALL have no effect on the active job.

Reset
REQ-015 rst low SHALL immediately force state IDLE and the pointer to requester 1 (so requester 0 wins first).
REQ-016 rst low SHALL immediately force all outputs to 0: req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_cs_enc, eng_cs_dec, eng_msg, eng_key, job_count.
REQ-017 Reset asserted mid-job SHALL abandon the job with no response. A later eng_done SHALL be ignored.

Configuration
REQ-018 With AES_SCHED_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT and increment each WAIT cycle.
- When the counter reaches TIMEOUT_CYCLES without eng_done: enter RESP with rsp_data=0 and rsp_err=1.
- eng_done arriving in the same cycle as the limit SHALL take priority and yield a normal response.
REQ-019 Without AES_SCHED_TIMEOUT_EN, WAIT SHALL persist until eng_done, rsp_err SHALL be constant 0, and no counter logic SHALL be present.

Verification
REQ-020 Single encrypt: req_valid=01, req_msg[127:0]=00112233445566778899aabbccddeeff, eng_done after 5 WAIT cycles with eng_result=8ea2b7ca516745bfeafc49904b496089 -> eng_cs_enc=1, one eng_start pulse, rsp_valid=01, rsp_data=8ea2…6089, job_count=1.
REQ-021 Contention: req_valid=11 held for four jobs -> grant order 0,1,0,1; eng_cs_dec=1 only during jobs 2 and 4.
REQ-022 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=00, job_count unchanged until rsp_ready=1.
REQ-023 Reset mid-WAIT: rst=0 for one cycle, then eng_done=1 -> no rsp_valid, all outputs 0, next request served normally.
REQ-024 Timeout (macro defined, TIMEOUT_CYCLES=16): eng_done never asserted -> rsp_valid after 16 WAIT cycles with rsp_err=1 and rsp_data=0. Repeat with eng_done on cycle 16 -> rsp_err=0.
REQ-025 Wrap: preload job_count via 65536 completed jobs -> job_count returns to 0x0000.
